// File: rtl/nap_controller_p.sv
// Power-nap sequencer: keypad duration entry, minute countdown, alarm with
// bounded snooze and unattended-alarm auto-cancel.
module nap_controller_p #(
  parameter int unsigned TICK_DIV      = 6000,
  parameter int unsigned DIGITS        = 2,
  parameter int unsigned MAX_SNOOZE    = 3,
  parameter int unsigned SNOOZE_MIN    = 5,
  parameter int unsigned ALARM_TIMEOUT = 10,
  localparam int unsigned MW = $clog2(10 ** DIGITS),
  localparam int unsigned SW = (MAX_SNOOZE == 0) ? 1 : $clog2(MAX_SNOOZE + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          switch,
  input  logic [9:0]    keypad,
  input  logic          sharp,
  input  logic          star,
  output logic [2:0]    state,
  output logic          init,
  output logic          en_setting,
  output logic          en_sleep,
  output logic          en_alarm,
  output logic          en_snooze,
  output logic          done,
  output logic [MW-1:0] remaining,
  output logic [SW-1:0] snooze_count
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned AW = $clog2(ALARM_TIMEOUT + 1);
  localparam int unsigned DW = $clog2(DIGITS + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTING = 3'd1,
    SLEEP   = 3'd2,
    ALARM   = 3'd3,
    SNOOZE  = 3'd4,
    CANCEL  = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [MW-1:0] entry_q, entry_d;
  logic [MW-1:0] rem_q, rem_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [AW-1:0] atimer_q, atimer_d;
  logic [SW-1:0] snz_q, snz_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [9:0]    keypad_q;
  logic          sharp_q, star_q;

  logic       key_valid, sharp_e, star_e, tick;
  logic [3:0] digit;

  always_comb begin
    digit = '0;
    for (int unsigned i = 0; i < 10; i++)
      if (keypad[i]) digit = 4'(i);
  end

  assign key_valid = (keypad != '0) && ((keypad & (keypad - 10'd1)) == '0) &&
                     (keypad_q == '0);
  assign sharp_e   = sharp & ~sharp_q;
  assign star_e    = star & ~star_q;
  assign tick      = (presc_q == PW'(TICK_DIV - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      entry_q  <= '0;
      rem_q    <= '0;
      presc_q  <= '0;
      atimer_q <= '0;
      snz_q    <= '0;
      dcnt_q   <= '0;
      keypad_q <= '0;
      sharp_q  <= 1'b0;
      star_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      entry_q  <= entry_d;
      rem_q    <= rem_d;
      presc_q  <= presc_d;
      atimer_q <= atimer_d;
      snz_q    <= snz_d;
      dcnt_q   <= dcnt_d;
      keypad_q <= keypad;
      sharp_q  <= sharp;
      star_q   <= star;
    end
  end

  always_comb begin
    state_d  = state_q;
    entry_d  = entry_q;
    rem_d    = rem_q;
    presc_d  = presc_q;
    atimer_d = atimer_q;
    snz_d    = snz_q;
    dcnt_d   = dcnt_q;
    case (state_q)
      IDLE: begin
        if (switch) begin
          state_d = SETTING;
          entry_d = '0;
          dcnt_d  = '0;
        end
      end
      SETTING: begin
        if (!switch) begin
          state_d = IDLE;
        end else if (sharp_e && entry_q != '0) begin
          state_d = SLEEP;
          rem_d   = entry_q;
          presc_d = '0;
        end else if (key_valid && dcnt_q < DW'(DIGITS)) begin
          entry_d = entry_q * MW'(10) + MW'(digit);
          dcnt_d  = dcnt_q + DW'(1);
        end
      end
      SLEEP, SNOOZE: begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        // Cancel outranks a same-cycle expiry; the <=1 test keeps remaining from wrapping
        if (sharp_e || !switch) begin
          state_d = CANCEL;
        end else if (tick) begin
          if (rem_q <= MW'(1)) begin
            state_d  = ALARM;
            rem_d    = '0;
            atimer_d = '0;
          end else begin
            rem_d = rem_q - MW'(1);
          end
        end
      end
      ALARM: begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        if (tick) atimer_d = atimer_q + AW'(1);
        if (sharp_e) begin
          state_d = CANCEL;
        end else if (star_e && snz_q < SW'(MAX_SNOOZE)) begin
          state_d = SNOOZE;
          rem_d   = MW'(SNOOZE_MIN);
          snz_d   = snz_q + SW'(1);
          presc_d = '0;
        end else if (tick && atimer_q == AW'(ALARM_TIMEOUT - 1)) begin
          state_d = CANCEL;
        end else if (!switch) begin
          state_d = CANCEL;
        end
      end
      CANCEL:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Counters are cleared on the way into CANCEL so the done cycle already shows zeros
    if (state_d == CANCEL) begin
      entry_d  = '0;
      rem_d    = '0;
      snz_d    = '0;
      presc_d  = '0;
      atimer_d = '0;
      dcnt_d   = '0;
    end
  end

  assign state        = state_q;
  assign init         = (state_q == IDLE);
  assign en_setting   = (state_q == SETTING);
  assign en_sleep     = (state_q == SLEEP);
  assign en_alarm     = (state_q == ALARM);
  assign en_snooze    = (state_q == SNOOZE);
  assign done         = (state_q == CANCEL);
  assign remaining    = (state_q == SETTING) ? entry_q :
                        (state_q == SLEEP || state_q == SNOOZE) ? rem_q : '0;
  assign snooze_count = snz_q;

endmodule

// File: tb/tb_nap_controller_p.sv
// Directed bench for nap_controller_p with TICK_DIV=4 and default limits.
module tb_nap_controller_p;

  logic       clock, reset, switch, sharp, star;
  logic [9:0] keypad;
  logic [2:0] state;
  logic       init, en_setting, en_sleep, en_alarm, en_snooze, done;
  logic [6:0] remaining;
  logic [1:0] snooze_count;

  int tests = 0;
  int fails = 0;

  nap_controller_p #(
    .TICK_DIV(4),
    .DIGITS(2),
    .MAX_SNOOZE(3),
    .SNOOZE_MIN(5),
    .ALARM_TIMEOUT(10)
  ) dut (
    .clock(clock), .reset(reset), .switch(switch), .keypad(keypad),
    .sharp(sharp), .star(star), .state(state), .init(init),
    .en_setting(en_setting), .en_sleep(en_sleep), .en_alarm(en_alarm),
    .en_snooze(en_snooze), .done(done), .remaining(remaining),
    .snooze_count(snooze_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic press_key(input int d);
    keypad = 10'd1 << d;
    step(1);
    keypad = '0;
    step(1);
  endtask

  initial begin
    reset = 1'b1; switch = 1'b0; sharp = 1'b0; star = 1'b0; keypad = '0;
    step(3);
    chk("rst_state", state, 0);
    chk("rst_init", init, 1);
    chk("rst_en", {en_setting, en_sleep, en_alarm, en_snooze}, 0);
    chk("rst_done", done, 0);
    chk("rst_remaining", remaining, 0);
    chk("rst_snooze", snooze_count, 0);
    reset = 1'b0;
    step(1);

    // basic nap 12 minutes
    switch = 1'b1;
    step(1);
    chk("idle_to_setting", state, 1);
    chk("en_setting", en_setting, 1);
    press_key(1);
    chk("entry_1", remaining, 1);
    press_key(2);
    chk("entry_12", remaining, 12);
    sharp = 1'b1; step(1); sharp = 1'b0;
    chk("sleep_state", state, 2);
    chk("en_sleep", en_sleep, 1);
    chk("sleep_rem_start", remaining, 12);
    step(3);
    chk("sleep_rem_pre_tick", remaining, 12);
    step(1);
    chk("sleep_rem_tick1", remaining, 11);
    step(43);
    chk("sleep_cycle47_state", state, 2);
    chk("sleep_cycle47_rem", remaining, 1);
    step(1);
    chk("alarm_at_48", state, 3);
    chk("en_alarm", en_alarm, 1);
    chk("alarm_rem", remaining, 0);
    sharp = 1'b1; step(1); sharp = 1'b0;
    chk("alarm_sharp_cancel", state, 5);
    chk("cancel_done", done, 1);
    step(1);
    chk("cancel_to_idle", state, 0);
    chk("idle_done_low", done, 0);
    step(1);
    chk("reenter_setting", state, 1);
    chk("reenter_entry0", remaining, 0);

    // invalid multi-bit key and held key
    keypad = 10'h003; step(2); keypad = '0; step(1);
    chk("multibit_ignored", remaining, 0);
    keypad = 10'd1 << 4; step(10); keypad = '0; step(1);
    chk("held_key_once", remaining, 4);
    switch = 1'b0; step(1);
    chk("setting_switch_off", state, 0);
    switch = 1'b1; step(1);
    chk("setting_again", state, 1);
    chk("entry_cleared", remaining, 0);
    press_key(9); press_key(9); press_key(9);
    chk("digit_limit_99", remaining, 99);
    sharp = 1'b1; switch = 1'b0; step(1); sharp = 1'b0;
    chk("switch_over_sharp", state, 0);

    // zero entry then 3 minutes, sharp on expiry tick
    switch = 1'b1; step(1);
    press_key(0);
    chk("zero_entry", remaining, 0);
    sharp = 1'b1; step(1); sharp = 1'b0; step(1);
    chk("zero_sharp_ignored", state, 1);
    press_key(3);
    chk("entry_3", remaining, 3);
    sharp = 1'b1; step(1); sharp = 1'b0;
    chk("sleep3_state", state, 2);
    chk("sleep3_rem", remaining, 3);
    step(11);
    chk("sleep3_last_min", remaining, 1);
    sharp = 1'b1; step(1); sharp = 1'b0;
    chk("sharp_on_expiry", state, 5);
    chk("sharp_on_expiry_done", done, 1);
    step(2);
    chk("back_to_setting", state, 1);

    // snooze limit and timeout
    press_key(1);
    sharp = 1'b1; step(1); sharp = 1'b0;
    step(4);
    chk("alarm_1min", state, 3);
    for (int k = 1; k <= 3; k++) begin
      star = 1'b1; step(1); star = 1'b0;
      chk("snooze_state", state, 4);
      chk("snooze_rem", remaining, 5);
      chk("snooze_cnt", snooze_count, k);
      step(19);
      chk("snooze_rem_last", remaining, 1);
      step(1);
      chk("snooze_expire_alarm", state, 3);
    end
    star = 1'b1; step(1); star = 1'b0;
    chk("fourth_star_ignored", state, 3);
    chk("fourth_star_cnt", snooze_count, 3);
    step(38);
    chk("alarm_before_timeout", state, 3);
    chk("no_done_before_timeout", done, 0);
    step(1);
    chk("timeout_cancel", state, 5);
    chk("timeout_done", done, 1);
    step(1);
    chk("timeout_done_once", done, 0);
    chk("snooze_cleared", snooze_count, 0);
    step(1);

    // simultaneous sharp and star in ALARM
    press_key(1);
    sharp = 1'b1; step(1); sharp = 1'b0;
    step(4);
    chk("alarm_again", state, 3);
    sharp = 1'b1; star = 1'b1; step(1); sharp = 1'b0; star = 1'b0;
    chk("sharp_beats_star", state, 5);
    chk("sharp_beats_star_cnt", snooze_count, 0);
    step(2);

    // async reset in SNOOZE
    press_key(2);
    sharp = 1'b1; step(1); sharp = 1'b0;
    step(8);
    chk("alarm_2min", state, 3);
    star = 1'b1; step(1); star = 1'b0;
    step(3);
    chk("pre_reset_snooze", state, 4);
    #3;
    reset = 1'b1;
    #1;
    chk("async_rst_state", state, 0);
    chk("async_rst_init", init, 1);
    chk("async_rst_done", done, 0);
    switch = 1'b0;
    step(2);
    chk("rst_held_done", done, 0);
    reset = 1'b0;
    step(2);
    chk("post_rst_state", state, 0);
    chk("post_rst_done", done, 0);
    chk("post_rst_rem", remaining, 0);
    chk("post_rst_snooze", snooze_count, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nap_controller_p.md
Name: nap_controller_p

Overview:
- Parametrised next-generation power-nap controller.
- Accepts a nap duration in minutes from the one-hot keypad, counts it down on an internal minute prescaler, then raises the alarm.
- Supports a bounded number of snoozes and auto-cancels an unattended alarm.
- Sits between the keypad/switch front end and the display/buzzer blocks, replacing the fixed setting/sleep/alarm/cancel sequencer.

Parameters:
- TICK_DIV, 6000: clock cycles per minute tick; must be >= 2.
- DIGITS, 2: maximum decimal digits accepted for the duration. MW = clog2(10**DIGITS) is a derived localparam (7 for the default).
- MAX_SNOOZE, 3: maximum snoozes per nap; 0 disables snooze.
- SNOOZE_MIN, 5: snooze length in minutes; must be >= 1.
- ALARM_TIMEOUT, 10: minute ticks in ALARM before auto-cancel; must be >= 1.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- switch  in  1  nap enable level.
- keypad  in  10  one-hot digit keys 0..9, level while held.
- sharp  in  1  confirm/cancel key, level.
- star  in  1  snooze key, level.
- state  out  3  current state code.
- init, en_setting, en_sleep, en_alarm, en_snooze  out  1 each  one-hot decode of state.
- done  out  1  one-cycle pulse on CANCEL.
- remaining  out  MW  minutes left in SLEEP/SNOOZE; entry value in SETTING.
- snooze_count  out  clog2(MAX_SNOOZE+1)  snoozes used this nap.

Behaviour:
- Inputs are synchronous to clock; the block does not synchronise them.
- keypad, sharp and star are rising-edge detected against a registered copy.
- A keypad edge is valid only when the current vector has exactly one bit set and the previous vector was all-zero. Multi-bit vectors are ignored.
- All outputs are decoded from registers; there is no combinational input-to-output path.
- Every event acts on the clock edge after it is sampled.
- Encoding: IDLE=0, SETTING=1, SLEEP=2, ALARM=3, SNOOZE=4, CANCEL=5. Unused codes go to IDLE.
- Reset (async, while high): state=IDLE, init=1, all other outputs 0, and entry, prescaler, alarm-timer and snooze counter all cleared. Reset mid-nap aborts silently with no done pulse.
- IDLE: when switch=1, go to SETTING with entry=0.
- SETTING:
  - Valid digit d with fewer than DIGITS digits entered: entry = entry*10 + d. Further digits are ignored.
  - sharp edge with entry >= 1: go to SLEEP, remaining=entry, prescaler=0.
  - sharp edge with entry = 0: ignored.
  - switch=0: go to IDLE. This takes priority over sharp.
- SLEEP:
  - The prescaler counts 0..TICK_DIV-1; a tick occurs on the wrap.
  - On a tick, remaining decrements. On the tick with remaining=1, go to ALARM (remaining becomes 0) and clear the alarm timer.
  - sharp edge or switch=0: go to CANCEL. This has priority over a same-cycle expiry.
- ALARM:
  - en_alarm=1. The prescaler keeps running and the alarm timer counts ticks.
  - Priority order: sharp edge, then star edge, then timeout.
  - sharp edge: go to CANCEL.
  - star edge with snooze_count < MAX_SNOOZE: go to SNOOZE, remaining=SNOOZE_MIN, snooze_count+1, prescaler=0.
  - star edge at the limit: ignored.
  - Alarm timer reaches ALARM_TIMEOUT: go to CANCEL.
  - switch=0: go to CANCEL.
- SNOOZE:
  - Same countdown as SLEEP. On expiry, go to ALARM with the alarm timer cleared.
  - sharp edge or switch=0: go to CANCEL.
- CANCEL:
  - Lasts exactly one cycle with done=1.
  - Clears remaining, entry and snooze_count.
  - Next state is IDLE. If switch is still 1, the block re-enters SETTING one cycle later.
- Arithmetic:
  - remaining never underflows.
  - entry accumulates at MW bits; the DIGITS bound guarantees no overflow.

Test Plan:
- Basic nap (TICK_DIV=4): switch=1, keys 1 then 2, sharp. Required: remaining=12 in SLEEP, decrements every 4 cycles, ALARM 48 cycles after entering SLEEP.
- Digit limit and invalid keys: press 9,9,9 with DIGITS=2 -> entry=99. keypad=0x003 -> ignored. Holding a key for 10 cycles -> one digit only.
- Zero entry: keys 0 then sharp -> remains in SETTING, remaining=0. Then keys 3, sharp -> SLEEP with remaining=3.
- Snooze limit (MAX_SNOOZE=3): three star presses in successive ALARMs -> SNOOZE each time with remaining=5 and snooze_count 1,2,3. Fourth star -> ignored. Timeout after 10 ticks -> CANCEL, done pulses once, snooze_count=0.
- Simultaneous events: sharp and star on the same ALARM cycle -> CANCEL. sharp on the SLEEP expiry tick -> CANCEL, not ALARM.
- Reset mid-SNOOZE: assert reset asynchronously between clock edges -> state=0 and init=1 immediately, done never pulses, all counters 0 after release.
